// File: rtl/spram_bist_if.sv
// rtl/spram_bist_if.sv - SP256K bank bus shared by the BIST engine and its SPRAM instances
interface spram_bist_if #(
    parameter int NBANKS = 1
);
    logic [13:0]              ad;
    logic [NBANKS-1:0][15:0]  di;
    logic [3:0]               maskwe;
    logic                     we;
    logic                     cs;
    logic                     stdby;
    logic                     sleep;
    logic                     pwroff_n;
    logic [NBANKS-1:0][15:0]  dout;

    modport master (
        output ad, di, maskwe, we, cs, stdby, sleep, pwroff_n,
        input  dout
    );

    modport slave (
        input  ad, di, maskwe, we, cs, stdby, sleep, pwroff_n,
        output dout
    );
endinterface

// File: rtl/spram_bist.sv
// rtl/spram_bist.sv - write/read-compare BIST for NBANKS parallel SP256K blocks with pattern select
module spram_bist #(
    parameter int          ADDR_W   = 14,
    parameter int          NBANKS   = 1,
    parameter logic [15:0] SEED     = 16'h0000,
    parameter logic [15:0] STEP     = 16'd7,
    parameter int          INJ_ADDR = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              inject,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_addr,
    output logic [1:0]        err_bank,
    output logic [7:0]        err_count,
    output logic              led,
    spram_bist_if.master      ram
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAKE  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    // Small depths never reach bit 8, so the LED falls back to the address MSB.
    localparam int LED_BIT = (ADDR_W >= 9) ? 8 : ADDR_W - 1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       acc_q, acc_d;
    logic [1:0]        mode_q, mode_d;
    logic              inj_q, inj_d;
    logic [15:0]       exp_q, exp_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              valid_r1_q, valid_r1_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [1:0]        err_bank_q, err_bank_d;
    logic [7:0]        err_count_q, err_count_d;

    logic [15:0]       pat;
    logic              inj_hit;
    logic [2:0]        nmism;
    logic [1:0]        first_bank;
    logic [8:0]        err_sum;

    function automatic logic [15:0] pattern(input logic [1:0] m,
                                            input logic [ADDR_W-1:0] a,
                                            input logic [15:0] acc);
        case (m)
            2'd0:    pattern = acc;
            2'd1:    pattern = a[0] ? 16'hAAAA : 16'h5555;
            2'd2:    pattern = 16'(a);
            default: pattern = ~acc;
        endcase
    endfunction

    assign pat     = pattern(mode_q, addr_q, acc_q);
    assign inj_hit = inj_q && (state_q == S_WRITE) && (int'(addr_q) == INJ_ADDR);

    // SPRAM side: all banks share address and strobes, data carries a per-bank tag
    assign ram.ad       = 14'(addr_q);
    assign ram.maskwe   = 4'hF;
    assign ram.sleep    = 1'b0;
    assign ram.pwroff_n = 1'b1;
    assign ram.cs       = (state_q == S_WRITE) || (state_q == S_READ);
    assign ram.we       = (state_q == S_WRITE);
    assign ram.stdby    = !((state_q == S_WAKE) || (state_q == S_WRITE) ||
                            (state_q == S_READ) || (state_q == S_DRAIN));

    always_comb begin
        ram.di = '0;
        for (int b = 0; b < NBANKS; b++) begin
            ram.di[b] = pat ^ {2'(b), 14'b0};
            if (b == 0 && inj_hit) begin
                ram.di[b][0] = ~ram.di[b][0];
            end
        end
    end

    // Scan downward so the lowest mismatching bank is the one left in first_bank.
    always_comb begin
        nmism      = 3'd0;
        first_bank = 2'd0;
        for (int b = NBANKS - 1; b >= 0; b--) begin
            if (ram.dout[b] != (exp_q ^ {2'(b), 14'b0})) begin
                nmism      = nmism + 3'd1;
                first_bank = 2'(b);
            end
        end
    end

    assign err_sum = {1'b0, err_count_q} + 9'(nmism);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        inj_d       = inj_q;
        exp_d       = pat;
        exp_addr_d  = addr_q;
        valid_r1_d  = (state_q == S_READ);
        err_addr_d  = err_addr_q;
        err_bank_d  = err_bank_q;
        err_count_d = err_count_q;

        if (valid_r1_q && (nmism != 3'd0)) begin
            err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
            if (err_count_q == 8'd0) begin
                err_addr_d = exp_addr_q;
                err_bank_d = first_bank;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d      = mode;
                    inj_d       = inject;
                    err_addr_d  = '0;
                    err_bank_d  = 2'd0;
                    err_count_d = 8'd0;
                    acc_d       = SEED;
                    addr_d      = '0;
                    state_d     = S_WAKE;
                end
            end
            S_WAKE: state_d = S_WRITE;
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                acc_d  = acc_q + STEP;
                if (addr_q == ADDR_MAX) begin
                    acc_d   = SEED;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                addr_d = addr_q + ADDR_W'(1);
                acc_d  = acc_q + STEP;
                if (addr_q == ADDR_MAX) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            acc_q       <= 16'd0;
            mode_q      <= 2'd0;
            inj_q       <= 1'b0;
            exp_q       <= 16'd0;
            exp_addr_q  <= '0;
            valid_r1_q  <= 1'b0;
            err_addr_q  <= '0;
            err_bank_q  <= 2'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            inj_q       <= inj_d;
            exp_q       <= exp_d;
            exp_addr_q  <= exp_addr_d;
            valid_r1_q  <= valid_r1_d;
            err_addr_q  <= err_addr_d;
            err_bank_q  <= err_bank_d;
            err_count_q <= err_count_d;
        end
    end

    assign busy      = (state_q == S_WAKE) || (state_q == S_WRITE) ||
                       (state_q == S_READ) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_count_q == 8'd0);
    assign err_addr  = err_addr_q;
    assign err_bank  = err_bank_q;
    assign err_count = err_count_q;
    assign led       = done ? pass : (busy ? addr_q[LED_BIT] : 1'b0);

endmodule

// File: tb/tb_spram_bist.sv
// tb/tb_spram_bist.sv - scoreboard bench for spram_bist with behavioural SP256K banks
module tb_spram_bist;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic [1:0] mode;
    logic inject;

    logic       busy_a, done_a, pass_a, led_a;
    logic [3:0] err_addr_a;
    logic [1:0] err_bank_a;
    logic [7:0] err_count_a;
    logic       busy_b, done_b, pass_b, led_b;
    logic [8:0] err_addr_b;
    logic [1:0] err_bank_b;
    logic [7:0] err_count_b;

    spram_bist_if #(.NBANKS(4)) if_a ();
    spram_bist_if #(.NBANKS(2)) if_b ();

    spram_bist #(.ADDR_W(4), .NBANKS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .inject(inject),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_addr(err_addr_a),
        .err_bank(err_bank_a), .err_count(err_count_a), .led(led_a), .ram(if_a)
    );

    spram_bist #(.ADDR_W(9), .NBANKS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .inject(inject),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_addr(err_addr_b),
        .err_bank(err_bank_b), .err_count(err_count_b), .led(led_b), .ram(if_b)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_a [4][16];
    logic [15:0] raw_a [4];
    logic [15:0] clr_a [4];
    logic [15:0] flip_a [4];
    logic [15:0] mem_b [2][512];
    logic [15:0] raw_b [2];
    logic [15:0] flip_b [2];

    function automatic logic [15:0] wmask(input logic [3:0] m);
        return {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
    endfunction

    always @(posedge clk) begin
        if (if_a.cs && !if_a.stdby && !if_a.sleep && if_a.pwroff_n) begin
            for (int b = 0; b < 4; b++) begin
                if (if_a.we)
                    mem_a[b][if_a.ad[3:0]] <= (if_a.di[b] & wmask(if_a.maskwe)) |
                                              (mem_a[b][if_a.ad[3:0]] & ~wmask(if_a.maskwe));
                else
                    raw_a[b] <= mem_a[b][if_a.ad[3:0]];
            end
        end
        if (if_b.cs && !if_b.stdby && !if_b.sleep && if_b.pwroff_n) begin
            for (int b = 0; b < 2; b++) begin
                if (if_b.we)
                    mem_b[b][if_b.ad[8:0]] <= (if_b.di[b] & wmask(if_b.maskwe)) |
                                              (mem_b[b][if_b.ad[8:0]] & ~wmask(if_b.maskwe));
                else
                    raw_b[b] <= mem_b[b][if_b.ad[8:0]];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) if_a.dout[b] = (raw_a[b] & ~clr_a[b]) ^ flip_a[b];
        for (int b = 0; b < 2; b++) if_b.dout[b] = raw_b[b] ^ flip_b[b];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent word model: accumulator is SEED + a*STEP with SEED=0, STEP=7.
    function automatic logic [15:0] model_word(input int m, input int a, input int b, input bit inj);
        logic [15:0] acc, w;
        acc = 16'(a * 7);
        case (m)
            0:       w = acc;
            1:       w = ((a % 2) == 1) ? 16'hAAAA : 16'h5555;
            2:       w = 16'(a);
            default: w = ~acc;
        endcase
        w = w ^ 16'(b << 14);
        if (inj && b == 0 && a == 5) w = w ^ 16'h0001;
        return w;
    endfunction

    typedef struct {
        string tag;
        int    cycles;
        bit    pass;
        int    cnt;
        int    addr;
        int    bank;
    } exp_t;
    exp_t sb[$];

    task automatic run(input string tag, input bit use_b, input logic [1:0] m, input bit inj,
                       input bit poke, input bit pass_e, input int cnt_e, input int addr_e,
                       input int bank_e);
        int   cyc;
        exp_t e;
        sb.push_back('{tag, use_b ? 1026 : 34, pass_e, cnt_e, addr_e, bank_e});
        mode   = m;
        inject = inj;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0;
        while ((use_b ? busy_b : busy_a) && cyc < 2000) begin
            cyc++;
            if (!use_b && cyc == 5)  check({tag, "/led_w3"}, led_a, 1'b0);
            if (!use_b && cyc == 12) check({tag, "/led_w10"}, led_a, 1'b1);
            if (!use_b && cyc == 26) check({tag, "/led_r8"}, led_a, 1'b1);
            if (poke && cyc == 20) start_a = 1'b1;
            if (poke && cyc == 21) start_a = 1'b0;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({e.tag, "/cycles"}, cyc, e.cycles);
        if (use_b) begin
            check({e.tag, "/done"}, done_b, 1'b1);
            check({e.tag, "/pass"}, pass_b, e.pass);
            check({e.tag, "/count"}, err_count_b, e.cnt);
            check({e.tag, "/addr"}, err_addr_b, e.addr);
            check({e.tag, "/bank"}, err_bank_b, e.bank);
            check({e.tag, "/led"}, led_b, e.pass);
            check({e.tag, "/stdby_cs"}, {if_b.stdby, if_b.cs}, 2'b10);
        end else begin
            check({e.tag, "/done"}, done_a, 1'b1);
            check({e.tag, "/pass"}, pass_a, e.pass);
            check({e.tag, "/count"}, err_count_a, e.cnt);
            check({e.tag, "/addr"}, err_addr_a, e.addr);
            check({e.tag, "/bank"}, err_bank_a, e.bank);
            check({e.tag, "/led"}, led_a, e.pass);
            check({e.tag, "/stdby_cs"}, {if_a.stdby, if_a.cs}, 2'b10);
        end
    endtask

    task automatic mem_check_a(input string tag, input int m, input bit inj);
        int bad = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 16; a++)
                if (mem_a[b][a] !== model_word(m, a, b, inj)) bad++;
        check({tag, "/mem_words_bad"}, bad, 0);
    endtask

    task automatic mem_check_b(input string tag, input int m);
        int bad = 0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++)
                if (mem_b[b][a] !== model_word(m, a, b, 1'b0)) bad++;
        check({tag, "/mem_words_bad"}, bad, 0);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode    = 2'd0;
        inject  = 1'b0;
        for (int b = 0; b < 4; b++) begin clr_a[b] = 16'h0; flip_a[b] = 16'h0; end
        for (int b = 0; b < 2; b++) flip_b[b] = 16'h0;

        repeat (3) @(negedge clk);
        check("reset/outs", {busy_a, done_a, pass_a, led_a, err_count_a, err_addr_a, err_bank_a}, 0);
        check("reset/stdby_cs", {if_a.stdby, if_a.cs}, 2'b10);
        check("reset/sleep_pwr", {if_a.sleep, if_a.pwroff_n}, 2'b01);
        check("reset/b_outs", {busy_b, done_b, led_b, err_count_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("m0", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        check("m0/b0a3", mem_a[0][3], 16'h0015);
        check("m0/b1a3", mem_a[1][3], 16'h4015);
        mem_check_a("m0", 0, 1'b0);

        run("m1", 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        check("m1/b2a1", mem_a[2][1], 16'h2AAA);
        check("m1/b3a0", mem_a[3][0], 16'h9555);
        mem_check_a("m1", 1, 1'b0);

        run("m3_poke", 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        mem_check_a("m3", 3, 1'b0);

        run("inj", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1, 5, 0);
        check("inj/b0a5", mem_a[0][5], 16'h0022);
        mem_check_a("inj", 0, 1'b1);

        mode    = 2'd0;
        inject  = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!(if_a.we && if_a.cs && if_a.ad == 14'd6) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("rst_mid/wait_addr6", n < 100, 1'b1);
        check("rst_mid/busy_before", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid/outs", {busy_a, done_a, pass_a, led_a, err_count_a, err_addr_a, err_bank_a}, 0);
        check("rst_mid/stdby_cs", {if_a.stdby, if_a.cs, if_a.we}, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("post_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        mem_check_a("post_rst", 0, 1'b0);

        clr_a[1] = 16'h0008;
        run("m2_bit3", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8, 8, 1);
        clr_a[1] = 16'h0000;

        run("b_m0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        check("b_m0/b1a300", mem_b[1][300], 16'h4834);
        mem_check_b("b_m0", 0);

        flip_b[0] = 16'h0001;
        flip_b[1] = 16'h0001;
        run("b_sat", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 255, 0, 0);
        flip_b[0] = 16'h0000;
        flip_b[1] = 16'h0000;

        check("sb/empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
